// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and widths for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_FETCH,
      SRC_DATA
   } src_e;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;

endpackage

// File: rtl/mem_rsp_tracker.sv
// rtl/mem_rsp_tracker.sv - read-tag delay line that steers returned read data to its requester
module mem_rsp_tracker
   import mem_arb_pkg::*;
#(
   parameter int RD_LATENCY = 1
) (
   input  logic clk,
   input  logic reset,
   input  src_e push_tag,
   output logic rsp_fetch_valid,
   output logic rsp_data_valid
);

   src_e pipe [RD_LATENCY];

   // One slot per cycle of memory latency; reset drops every in-flight read.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe[i] <= SRC_NONE;
         end
      end else begin
         pipe[0] <= push_tag;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
         end
      end
   end

   assign rsp_fetch_valid = (pipe[RD_LATENCY-1] == SRC_FETCH);
   assign rsp_data_valid  = (pipe[RD_LATENCY-1] == SRC_DATA);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and load/store
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int RD_LATENCY     = 1,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_fetch_req,
   input  logic [ADDR_W-1:0] i_fetch_addr,
   output logic              o_fetch_gnt,
   output logic              o_fetch_rdvalid,
   output logic [DATA_W-1:0] o_fetch_rddata,
   input  logic              i_data_rd,
   input  logic              i_data_wr,
   input  logic [ADDR_W-1:0] i_data_addr,
   input  logic [DATA_W-1:0] i_data_wrdata,
   output logic              o_data_gnt,
   output logic              o_data_rdvalid,
   output logic [DATA_W-1:0] o_data_rddata,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_rd,
   output logic              o_mem_wr,
   output logic [DATA_W-1:0] o_mem_wrdata,
   input  logic [DATA_W-1:0] i_mem_rddata,
   input  logic              i_mem_waitrequest
);

   localparam logic [2:0] BURST_MAX = 3'(MAX_DATA_BURST);

   logic       data_req;
   logic       data_is_rd;
   logic       fetch_win;
   logic       data_win;
   logic       fetch_gnt;
   logic       data_gnt;
   logic [2:0] burst_cnt;
   src_e       push_tag;
   logic       rsp_fetch_valid;
   logic       rsp_data_valid;

   // Data normally wins; a full data burst with fetch waiting hands the port to fetch.
   always_comb begin
      data_req   = i_data_rd | i_data_wr;
      data_is_rd = i_data_rd & ~i_data_wr;
      fetch_win  = ~reset & i_fetch_req & (~data_req | (burst_cnt == BURST_MAX));
      data_win   = ~reset & data_req & ~fetch_win;
      fetch_gnt  = fetch_win & ~i_mem_waitrequest;
      data_gnt   = data_win & ~i_mem_waitrequest;
      push_tag   = SRC_NONE;
      if (fetch_gnt) begin
         push_tag = SRC_FETCH;
      end else if (data_gnt && data_is_rd) begin
         push_tag = SRC_DATA;
      end
   end

   assign o_fetch_gnt  = fetch_gnt;
   assign o_data_gnt   = data_gnt;
   assign o_mem_addr   = fetch_win ? i_fetch_addr : (data_win ? i_data_addr : '0);
   assign o_mem_rd     = fetch_win | (data_win & data_is_rd);
   assign o_mem_wr     = data_win & i_data_wr;
   assign o_mem_wrdata = data_win ? i_data_wrdata : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         burst_cnt <= '0;
      end else if (fetch_gnt || !i_fetch_req) begin
         burst_cnt <= '0;
      end else if (data_gnt && burst_cnt != BURST_MAX) begin
         burst_cnt <= burst_cnt + 3'd1;
      end
   end

   mem_rsp_tracker #(
      .RD_LATENCY (RD_LATENCY)
   ) u_rsp_tracker (
      .clk             (clk),
      .reset           (reset),
      .push_tag        (push_tag),
      .rsp_fetch_valid (rsp_fetch_valid),
      .rsp_data_valid  (rsp_data_valid)
   );

   assign o_fetch_rdvalid = rsp_fetch_valid;
   assign o_data_rdvalid  = rsp_data_valid;
   assign o_fetch_rddata  = rsp_fetch_valid ? i_mem_rddata : '0;
   assign o_data_rddata   = rsp_data_valid ? i_mem_rddata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at read latencies 1 and 3
module tb_mem_port_arbiter;

   localparam int MAXB = 4;
   localparam int SRC_F = 1;
   localparam int SRC_D = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        data_rd, data_wr;
   logic [15:0] data_addr, data_wrdata;
   logic [15:0] mem_rddata;
   logic        mem_waitrequest;

   logic        fetch_gnt1, fetch_rdvalid1, data_gnt1, data_rdvalid1, mem_rd1, mem_wr1;
   logic [15:0] fetch_rddata1, data_rddata1, mem_addr1, mem_wrdata1;
   logic        fetch_gnt3, fetch_rdvalid3, data_gnt3, data_rdvalid3, mem_rd3, mem_wr3;
   logic [15:0] fetch_rddata3, data_rddata3, mem_addr3, mem_wrdata3;

   always #5 clk = ~clk;

   mem_port_arbiter #(.RD_LATENCY(1), .MAX_DATA_BURST(MAXB)) u_dut1 (
      .clk(clk), .reset(reset),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_gnt(fetch_gnt1), .o_fetch_rdvalid(fetch_rdvalid1), .o_fetch_rddata(fetch_rddata1),
      .i_data_rd(data_rd), .i_data_wr(data_wr), .i_data_addr(data_addr), .i_data_wrdata(data_wrdata),
      .o_data_gnt(data_gnt1), .o_data_rdvalid(data_rdvalid1), .o_data_rddata(data_rddata1),
      .o_mem_addr(mem_addr1), .o_mem_rd(mem_rd1), .o_mem_wr(mem_wr1), .o_mem_wrdata(mem_wrdata1),
      .i_mem_rddata(mem_rddata), .i_mem_waitrequest(mem_waitrequest)
   );

   mem_port_arbiter #(.RD_LATENCY(3), .MAX_DATA_BURST(MAXB)) u_dut3 (
      .clk(clk), .reset(reset),
      .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
      .o_fetch_gnt(fetch_gnt3), .o_fetch_rdvalid(fetch_rdvalid3), .o_fetch_rddata(fetch_rddata3),
      .i_data_rd(data_rd), .i_data_wr(data_wr), .i_data_addr(data_addr), .i_data_wrdata(data_wrdata),
      .o_data_gnt(data_gnt3), .o_data_rdvalid(data_rdvalid3), .o_data_rddata(data_rddata3),
      .o_mem_addr(mem_addr3), .o_mem_rd(mem_rd3), .o_mem_wr(mem_wr3), .o_mem_wrdata(mem_wrdata3),
      .i_mem_rddata(mem_rddata), .i_mem_waitrequest(mem_waitrequest)
   );

   typedef struct {
      logic        fr;  logic [15:0] fa;
      logic        dr;  logic dw; logic [15:0] da; logic [15:0] wd;
      logic        wt;  logic [15:0] mrd;
      logic        fg;  logic dg; logic [15:0] ma; logic mr; logic mw; logic [15:0] mwd;
      logic        frv; logic [15:0] frd; logic drv; logic [15:0] drd;
   } vec_t;

   typedef struct {
      int due;
      int src;
   } rsp_t;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   m_burst = 0;
   rsp_t q1[$];
   rsp_t q3[$];
   vec_t tbl[$];

   logic        e_fg, e_dg, e_mr, e_mw, e_frv1, e_drv1, e_frv3, e_drv3;
   logic [15:0] e_ma, e_mwd;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(logic fr, logic [15:0] fa, logic dr, logic dw, logic [15:0] da,
                               logic [15:0] wd, logic wt, logic [15:0] mrd, logic fg, logic dg,
                               logic [15:0] ma, logic mr, logic mw, logic [15:0] mwd,
                               logic frv, logic [15:0] frd, logic drv, logic [15:0] drd);
      vec_t v;
      v.fr = fr; v.fa = fa; v.dr = dr; v.dw = dw; v.da = da; v.wd = wd; v.wt = wt; v.mrd = mrd;
      v.fg = fg; v.dg = dg; v.ma = ma; v.mr = mr; v.mw = mw; v.mwd = mwd;
      v.frv = frv; v.frd = frd; v.drv = drv; v.drd = drd;
      return v;
   endfunction

   task automatic set_in(input logic fr, input logic [15:0] fa, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] wd, input logic wt,
                         input logic [15:0] mrd);
      fetch_req = fr; fetch_addr = fa; data_rd = dr; data_wr = dw;
      data_addr = da; data_wrdata = wd; mem_waitrequest = wt; mem_rddata = mrd;
   endtask

   // Reference: port ownership from the priority rules, responses as a due-cycle queue.
   task automatic model_check();
      logic dreq, fwin, dwin;
      dreq = data_rd | data_wr;
      fwin = !reset && fetch_req && (!dreq || m_burst == MAXB);
      dwin = !reset && dreq && !fwin;
      e_fg  = fwin && !mem_waitrequest;
      e_dg  = dwin && !mem_waitrequest;
      e_ma  = fwin ? fetch_addr : (dwin ? data_addr : 16'h0);
      e_mr  = fwin || (dwin && data_rd && !data_wr);
      e_mw  = dwin && data_wr;
      e_mwd = dwin ? data_wrdata : 16'h0;
      e_frv1 = !reset && q1.size() > 0 && q1[0].due == cyc && q1[0].src == SRC_F;
      e_drv1 = !reset && q1.size() > 0 && q1[0].due == cyc && q1[0].src == SRC_D;
      e_frv3 = !reset && q3.size() > 0 && q3[0].due == cyc && q3[0].src == SRC_F;
      e_drv3 = !reset && q3.size() > 0 && q3[0].due == cyc && q3[0].src == SRC_D;
      chk("fetch_gnt", {15'b0, fetch_gnt1}, {15'b0, e_fg});
      chk("data_gnt", {15'b0, data_gnt1}, {15'b0, e_dg});
      chk("mem_addr", mem_addr1, e_ma);
      chk("mem_rd", {15'b0, mem_rd1}, {15'b0, e_mr});
      chk("mem_wr", {15'b0, mem_wr1}, {15'b0, e_mw});
      chk("mem_wrdata", mem_wrdata1, e_mwd);
      chk("fetch_rdvalid_l1", {15'b0, fetch_rdvalid1}, {15'b0, e_frv1});
      chk("fetch_rddata_l1", fetch_rddata1, e_frv1 ? mem_rddata : 16'h0);
      chk("data_rdvalid_l1", {15'b0, data_rdvalid1}, {15'b0, e_drv1});
      chk("data_rddata_l1", data_rddata1, e_drv1 ? mem_rddata : 16'h0);
      chk("arb_l3", {fetch_gnt3, data_gnt3, mem_rd3, mem_wr3, 12'b0}, {e_fg, e_dg, e_mr, e_mw, 12'b0});
      chk("mem_addr_l3", mem_addr3, e_ma);
      chk("mem_wrdata_l3", mem_wrdata3, e_mwd);
      chk("fetch_rdvalid_l3", {15'b0, fetch_rdvalid3}, {15'b0, e_frv3});
      chk("fetch_rddata_l3", fetch_rddata3, e_frv3 ? mem_rddata : 16'h0);
      chk("data_rdvalid_l3", {15'b0, data_rdvalid3}, {15'b0, e_drv3});
      chk("data_rddata_l3", data_rddata3, e_drv3 ? mem_rddata : 16'h0);
   endtask

   task automatic model_update();
      rsp_t r;
      if (reset) begin
         q1.delete();
         q3.delete();
         m_burst = 0;
      end else begin
         if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
         if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());
         r.src = e_fg ? SRC_F : SRC_D;
         if (e_fg || (e_dg && data_rd && !data_wr)) begin
            r.due = cyc + 1; q1.push_back(r);
            r.due = cyc + 3; q3.push_back(r);
         end
         if (e_fg || !fetch_req) m_burst = 0;
         else if (e_dg && m_burst < MAXB) m_burst = m_burst + 1;
      end
      cyc++;
   endtask

   task automatic tick();
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick_row(input vec_t v, input int idx);
      string s;
      set_in(v.fr, v.fa, v.dr, v.dw, v.da, v.wd, v.wt, v.mrd);
      @(negedge clk);
      s = $sformatf("row%0d_", idx);
      chk({s, "fetch_gnt"}, {15'b0, fetch_gnt1}, {15'b0, v.fg});
      chk({s, "data_gnt"}, {15'b0, data_gnt1}, {15'b0, v.dg});
      chk({s, "mem_addr"}, mem_addr1, v.ma);
      chk({s, "mem_rd"}, {15'b0, mem_rd1}, {15'b0, v.mr});
      chk({s, "mem_wr"}, {15'b0, mem_wr1}, {15'b0, v.mw});
      chk({s, "mem_wrdata"}, mem_wrdata1, v.mwd);
      chk({s, "fetch_rdvalid"}, {15'b0, fetch_rdvalid1}, {15'b0, v.frv});
      chk({s, "fetch_rddata"}, fetch_rddata1, v.frd);
      chk({s, "data_rdvalid"}, {15'b0, data_rdvalid1}, {15'b0, v.drv});
      chk({s, "data_rddata"}, data_rddata1, v.drd);
      model_check();
      @(posedge clk);
      model_update();
      #1;
   endtask

   initial begin
      int seen_fetch3;
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);

      // fetch-only stream
      tbl.push_back(mk(1,16'h0000,0,0,16'h0000,16'h0000,0,16'h0000, 1,0,16'h0000,1,0,16'h0000, 0,16'h0000,0,16'h0000));
      tbl.push_back(mk(1,16'h0002,0,0,16'h0000,16'h0000,0,16'h1111, 1,0,16'h0002,1,0,16'h0000, 1,16'h1111,0,16'h0000));
      tbl.push_back(mk(1,16'h0004,0,0,16'h0000,16'h0000,0,16'h2222, 1,0,16'h0004,1,0,16'h0000, 1,16'h2222,0,16'h0000));
      tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,16'h3333, 0,0,16'h0000,0,0,16'h0000, 1,16'h3333,0,16'h0000));
      // contention: data first, then fetch
      tbl.push_back(mk(1,16'h0010,1,0,16'h0200,16'h0000,0,16'h5555, 0,1,16'h0200,1,0,16'h0000, 0,16'h0000,0,16'h0000));
      tbl.push_back(mk(1,16'h0010,0,0,16'h0000,16'h0000,0,16'hAAAA, 1,0,16'h0010,1,0,16'h0000, 0,16'h0000,1,16'hAAAA));
      tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,16'h1234, 0,0,16'h0000,0,0,16'h0000, 1,16'h1234,0,16'h0000));
      // simultaneous rd+wr is a write only
      tbl.push_back(mk(0,16'h0000,1,1,16'h0040,16'h00FF,0,16'h0000, 0,1,16'h0040,0,1,16'h00FF, 0,16'h0000,0,16'h0000));
      tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,16'h7777, 0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000));
      // stalled write
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(0,16'h0000,0,1,16'h0300,16'hBEEF,1,16'h0000, 0,0,16'h0300,0,1,16'hBEEF, 0,16'h0000,0,16'h0000));
      tbl.push_back(mk(0,16'h0000,0,1,16'h0300,16'hBEEF,0,16'h0000, 0,1,16'h0300,0,1,16'hBEEF, 0,16'h0000,0,16'h0000));
      tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,16'h9999, 0,0,16'h0000,0,0,16'h0000, 0,16'h0000,0,16'h0000));
      // starvation guard: four data grants, then fetch, then data again
      tbl.push_back(mk(1,16'h0100,1,0,16'h0400,16'h0000,0,16'hD000, 0,1,16'h0400,1,0,16'h0000, 0,16'h0000,0,16'h0000));
      for (int i = 1; i < 4; i++)
         tbl.push_back(mk(1,16'h0100,1,0,16'h0400,16'h0000,0,16'hD000 + 16'(i), 0,1,16'h0400,1,0,16'h0000, 0,16'h0000,1,16'hD000 + 16'(i)));
      tbl.push_back(mk(1,16'h0100,1,0,16'h0400,16'h0000,0,16'hD004, 1,0,16'h0100,1,0,16'h0000, 0,16'h0000,1,16'hD004));
      tbl.push_back(mk(1,16'h0100,1,0,16'h0400,16'h0000,0,16'hD005, 0,1,16'h0400,1,0,16'h0000, 1,16'hD005,0,16'h0000));
      tbl.push_back(mk(0,16'h0000,0,0,16'h0000,16'h0000,0,16'hD006, 0,0,16'h0000,0,0,16'h0000, 0,16'h0000,1,16'hD006));

      // reset state, with requests asserted so gating is exercised
      set_in(1, 16'h1234, 1, 1, 16'h5678, 16'h9ABC, 0, 16'hFFFF);
      tick();
      tick();
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      for (int i = 0; i < tbl.size(); i++) tick_row(tbl[i], i);

      // reset one cycle after a latency-3 fetch is granted: the read must vanish
      set_in(1, 16'h0800, 0, 0, 0, 0, 0, 16'h4444);
      tick();
      reset = 1'b1;
      set_in(1, 16'h0800, 0, 1, 16'h0900, 16'h1357, 0, 16'h4444);
      tick();
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 16'h4444);
      seen_fetch3 = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (fetch_rdvalid3) seen_fetch3++;
         @(posedge clk);
         #1;
         tick();
      end
      chk("dropped_read_rdvalid", 16'(seen_fetch3), 16'h0);

      // randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         fetch_req       = ($urandom_range(0, 9) < 7);
         fetch_addr      = 16'($urandom);
         data_rd         = ($urandom_range(0, 9) < 5);
         data_wr         = ($urandom_range(0, 9) < 3);
         data_addr       = 16'($urandom);
         data_wrdata     = 16'($urandom);
         mem_waitrequest = ($urandom_range(0, 9) < 2);
         mem_rddata      = 16'($urandom);
         reset           = ($urandom_range(0, 299) == 0);
         tick();
      end
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the CPU's single 16-bit memory port between two requesters: the instruction-fetch path and the load/store data path. It grants at most one command per cycle and drives the memory strobes. It tracks outstanding reads by source tag and routes returned read data to the requester that issued the read. It sits between the CPU core and the memory, and replaces the direct PC/Ry address mux on o_mem_addr.

Parameters:
RD_LATENCY, 1, cycles from an accepted read command to valid i_mem_rddata (legal range 1..4)
MAX_DATA_BURST, 4, maximum consecutive data grants while a fetch is pending before fetch is forced to win

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
i_fetch_req  input  1  fetch read request; held until granted
i_fetch_addr  input  16  fetch byte address
o_fetch_gnt  output  1  fetch command accepted this cycle
o_fetch_rdvalid  output  1  o_fetch_rddata valid this cycle
o_fetch_rddata  output  16  fetched instruction word
i_data_rd  input  1  data read request; held until granted
i_data_wr  input  1  data write request; held until granted
i_data_addr  input  16  data byte address
i_data_wrdata  input  16  store data
o_data_gnt  output  1  data command accepted this cycle
o_data_rdvalid  output  1  o_data_rddata valid this cycle
o_data_rddata  output  16  load data
o_mem_addr  output  16  memory address
o_mem_rd  output  1  memory read strobe
o_mem_wr  output  1  memory write strobe
o_mem_wrdata  output  16  memory write data
i_mem_rddata  input  16  memory read data
i_mem_waitrequest  input  1  memory stall; the command presented is not accepted

Behaviour:
- Reset (asynchronous, active-high): while asserted, all grants, strobes and rdvalids are 0 and all rddata outputs are 0. The tag pipeline and the burst counter clear to 0. In-flight reads are dropped and never produce rdvalid after reset.
- Arbitration is combinational within the cycle. Data has priority over fetch, except when burst_cnt == MAX_DATA_BURST and i_fetch_req=1; in that case fetch wins.
- The winner's address, strobe and wrdata drive o_mem_*. When there is no request, o_mem_rd = o_mem_wr = 0, and o_mem_addr and o_mem_wrdata are 0.
- gnt = winner & ~i_mem_waitrequest. The loser's gnt is 0. A requester keeps its request and address stable until gnt; the arbiter does not latch requests.
- When i_mem_waitrequest=1, the strobes stay driven, no gnt is issued, and the tag pipeline shifts in NONE.
- If i_data_rd and i_data_wr are both 1, this is a write only: o_mem_rd=0, and no read tag is pushed.
- Fetch never writes. o_mem_wrdata is 0 whenever fetch is the winner.
- Tag pipeline: an RD_LATENCY-deep shift register of src_e, shifting every cycle.
  - An accepted read pushes FETCH or DATA. Any other cycle pushes NONE.
  - The output stage selects rdvalid: tag FETCH gives o_fetch_rdvalid=1, tag DATA gives o_data_rdvalid=1.
- Read data outputs equal i_mem_rddata when the matching rdvalid is 1, and 0 otherwise. They are combinational, with no extra latency.
- Back-to-back reads are accepted every cycle. Responses return in issue order, exactly RD_LATENCY cycles after their gnt.
- Burst counter, 3 bits, saturating at MAX_DATA_BURST:
  - increments on each data gnt while i_fetch_req=1;
  - clears on a fetch gnt or when i_fetch_req=0;
  - holds during waitrequest.
- Writes produce no response. o_data_gnt is the store completion.
- Addresses pass through unmodified; alignment is the requester's responsibility.

Decomposition:
- Package mem_arb_pkg contains:
  - typedef enum logic [1:0] src_e {SRC_NONE, SRC_FETCH, SRC_DATA};
  - localparam ADDR_W = 16, DATA_W = 16.
- Sub-module mem_rsp_tracker (parameter RD_LATENCY) implements the tag shift register. Inputs: push_tag. Outputs: rsp_fetch_valid, rsp_data_valid.
- Arbitration, muxing and the burst counter stay in the top module.

Test Plan:
- Fetch-only stream: i_fetch_req=1 with addresses 0x0000, 0x0002, 0x0004 on consecutive cycles, RD_LATENCY=1, memory returns 0x1111/0x2222/0x3333 → o_fetch_gnt=1 each cycle, o_fetch_rdvalid pulses one cycle after each grant with the matching data, o_data_rdvalid stays 0.
- Contention: fetch@0x0010 and data rd@0x0200 in the same cycle → o_data_gnt=1, o_fetch_gnt=0, o_mem_addr=0x0200. The next cycle grants fetch, o_mem_addr=0x0010. The responses route to data then fetch.
- Starvation guard, MAX_DATA_BURST=4: data rd held continuously with fetch pending → exactly 4 data grants, then the 5th cycle grants fetch, then burst_cnt=0 and data wins again.
- Waitrequest: data wr@0x0300 with wrdata=0xBEEF and i_mem_waitrequest=1 for 3 cycles → o_mem_wr=1 with addr and wrdata stable, o_data_gnt=0 for 3 cycles, then gnt=1 in the 4th cycle; no rdvalid at any time.
- Simultaneous rd+wr: i_data_rd=i_data_wr=1 @0x0040 → o_mem_wr=1, o_mem_rd=0, o_data_gnt=1, and no o_data_rdvalid RD_LATENCY cycles later.
- Reset mid-flight, RD_LATENCY=3: grant a fetch read, assert reset 1 cycle later for 1 cycle → all outputs 0 during reset, and no o_fetch_rdvalid is ever produced for the dropped read.
